// File: rtl/wb_master_if.sv
// wb_master_if: CPU-side to Wishbone classic master bridge with ack timeout.
// Revision: 1.0
`default_nettype none

module wb_master_if #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stall_req_o,
  output logic        err_o,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i
);

  localparam logic [15:0] c_TIMEOUT = 16'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE           = 2'd0,
    S_BUSY           = 2'd1,
    S_WAIT_FOR_STALL = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_we;
  logic [3:0]  r_sel;
  logic        r_stb;
  logic        r_cyc;
  logic [31:0] r_rd_buf;
  logic [15:0] r_cnt;
  logic        r_err;

  logic        w_busy;
  logic [15:0] w_cnt_nxt;

  assign w_busy    = (r_state == S_BUSY);
  assign w_cnt_nxt = r_cnt + 16'd1;

  assign wishbone_addr_o = r_addr;
  assign wishbone_data_o = r_data;
  assign wishbone_we_o   = r_we;
  assign wishbone_sel_o  = r_sel;
  assign wishbone_stb_o  = r_stb;
  assign wishbone_cyc_o  = r_cyc;
  assign err_o           = r_err;

  always_comb begin
    stall_req_o = 1'b0;
    cpu_data_o  = 32'd0;
    if (r_state == S_IDLE)
      stall_req_o = cpu_ce_i && !flush_i;
    else if (w_busy)
      stall_req_o = !wishbone_ack_i;
    // Read data bypasses rd_buf in the ack cycle so the CPU sees it without delay.
    if (w_busy && wishbone_ack_i && !r_we)
      cpu_data_o = wishbone_data_i;
    else if (r_state == S_WAIT_FOR_STALL)
      cpu_data_o = r_rd_buf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'd0;
      r_data   <= 32'd0;
      r_we     <= 1'b0;
      r_sel    <= 4'd0;
      r_stb    <= 1'b0;
      r_cyc    <= 1'b0;
      r_rd_buf <= 32'd0;
      r_cnt    <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            r_addr  <= cpu_addr_i;
            r_data  <= cpu_data_i;
            r_we    <= cpu_we_i;
            r_sel   <= cpu_sel_i;
            r_stb   <= 1'b1;
            r_cyc   <= 1'b1;
            r_cnt   <= 16'd0;
            r_state <= S_BUSY;
          end else begin
            r_addr <= 32'd0;
            r_data <= 32'd0;
            r_we   <= 1'b0;
            r_sel  <= 4'd0;
            r_stb  <= 1'b0;
            r_cyc  <= 1'b0;
          end
        end
        S_BUSY: begin
          // Ack takes priority over a coincident flush; the flush then lands in IDLE.
          if (wishbone_ack_i || flush_i || (w_cnt_nxt == c_TIMEOUT)) begin
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_stb   <= 1'b0;
            r_cyc   <= 1'b0;
            r_state <= S_IDLE;
            if (wishbone_ack_i) begin
              if (!r_we)
                r_rd_buf <= wishbone_data_i;
              if (stall_i)
                r_state <= S_WAIT_FOR_STALL;
            end else if (!flush_i) begin
              r_err <= 1'b1;
              r_cnt <= w_cnt_nxt;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_WAIT_FOR_STALL: begin
          if (!stall_i || flush_i)
            r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_stb   <= 1'b0;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/wb_master_if.md
WB_MASTER_IF -- requirements
Module: wb_master_if

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: max cycles in BUSY without ack before abort (legal 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cpu_ce_i  input  1  CPU access request.
REQ-005 SHALL have port cpu_we_i  input  1  1 = write, 0 = read.
REQ-006 SHALL have port cpu_addr_i  input  32  byte address.
REQ-007 SHALL have port cpu_data_i  input  32  write data.
REQ-008 SHALL have port cpu_sel_i  input  4  byte enables.
REQ-009 SHALL have port stall_i  input  1  pipeline frozen by another source.
REQ-010 SHALL have port flush_i  input  1  pipeline flush; abandon access.
REQ-011 SHALL have port cpu_data_o  output  32  read data to CPU.
REQ-012 SHALL have port stall_req_o  output  1  request pipeline stall while access is outstanding.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse on ack timeout.
REQ-014 SHALL have ports wishbone_addr_o 32, wishbone_data_o 32, wishbone_we_o 1, wishbone_sel_o 4, wishbone_stb_o 1, wishbone_cyc_o 1 (outputs); wishbone_data_i 32, wishbone_ack_i 1 (inputs).

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, WAIT_FOR_STALL; all Wishbone outputs registered.
REQ-016 IDLE, cpu_ce_i=1, flush_i=0: next edge SHALL register cyc=stb=1 plus addr/data/we/sel from CPU inputs, go BUSY, clear timeout counter.
REQ-017 IDLE, cpu_ce_i=0 or flush_i=1: SHALL stay IDLE, cyc=stb=we=0, sel=0, addr/data_o=0.
REQ-018 BUSY: Wishbone outputs SHALL hold stable until ack_i or abort.
REQ-019 BUSY, ack_i=1: next edge SHALL drive cyc=stb=we=0, sel=0, addr/data_o=0; read data SHALL be latched into rd_buf when we=0; next state WAIT_FOR_STALL if stall_i=1, else IDLE.
REQ-020 BUSY, flush_i=1, ack_i=0: SHALL drop cyc/stb next edge, go IDLE, no err_o, data discarded; if flush_i and ack_i coincide, ack wins (REQ-019), then flush applies in IDLE.
REQ-021 BUSY: counter SHALL increment each cycle without ack; on reaching ACK_TIMEOUT, SHALL drop cyc/stb, pulse err_o one cycle, go IDLE.
REQ-022 WAIT_FOR_STALL: SHALL hold rd_buf; go IDLE when stall_i=0; flush_i=1 SHALL also return to IDLE.
REQ-023 stall_req_o (combinational) SHALL be 1 in IDLE when cpu_ce_i=1 and flush_i=0, 1 in BUSY when ack_i=0, else 0.
REQ-024 cpu_data_o (combinational) SHALL be wishbone_data_i in BUSY with ack_i=1 and we=0; rd_buf in WAIT_FOR_STALL; 0 otherwise.
REQ-025 stb/cyc SHALL be low for at least one cycle between consecutive accesses, so slaves detect each request edge.
REQ-026 wishbone_ack_i outside BUSY SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, all Wishbone outputs 0, rd_buf 0, counter 0, err_o 0, independent of clk.
REQ-028 Reset asserted mid-BUSY SHALL abort access with no err_o; first request after release SHALL start from IDLE per REQ-016.

Verification
REQ-029 Read: ce=1, we=0, addr=0x0000_0010, slave acks 2 cycles after stb with 0xDEADBEEF -> stb high 3 cycles, cpu_data_o=0xDEADBEEF in ack cycle, stall_req_o falls same cycle.
REQ-030 Write: ce=1, we=1, addr=0x24, data=0x12345678, sel=0xF -> bus holds values until ack, then all zero; cpu_data_o stays 0.
REQ-031 Read with stall_i=1 at ack, held 3 cycles -> WAIT_FOR_STALL 3 cycles, cpu_data_o=read value throughout, IDLE when stall_i=0.
REQ-032 Back-to-back reads, ce held 1 -> stb shows one low cycle between accesses; two distinct acks.
REQ-033 No ack, ACK_TIMEOUT=4 -> cyc/stb drop after 4 BUSY cycles, err_o high exactly one cycle, stall_req_o 0.
REQ-034 flush_i=1 in 2nd BUSY cycle; rst_n pulsed low mid-BUSY -> cyc/stb drop, IDLE, no err_o, outputs 0.
